alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port reqi_valid  input  1  requester i (i = 0, 1) presents an operation.
REQ-005 SHALL have port reqi_ready  output  1  arbiter accepts requester i this cycle.
REQ-006 SHALL have port reqi_a, reqi_b  input  WIDTH  operands of requester i.
REQ-007 SHALL have port reqi_ctrl  input  3  ALU control code (000 ADD … 111 XOR) of requester i.
REQ-008 SHALL have port reqi_funct3  input  3  funct3 of requester i (selects SLT vs SLTU).
REQ-009 SHALL have port reqi_funct7b5  input  1  SRA vs SRL select of requester i.
REQ-010 SHALL have port respi_valid  output  1  result for requester i available.
REQ-011 SHALL have port respi_ready  input  1  requester i consumes result.
REQ-012 SHALL have port resp_result  output  WIDTH  registered ALU result, shared by both responses.
REQ-013 SHALL have port resp_zero  output  1  registered zero flag of resp_result.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-016 IDLE: grant = requester chosen by arbitration among asserted reqi_valid; reqi_ready = (state==IDLE) && grant==i, combinational; at most one reqi_ready high.
REQ-017 Accept (reqi_valid && reqi_ready): latch a, b, ctrl, funct3, funct7b5 and owner id; IDLE -> EXEC.
REQ-018 IDLE with no reqi_valid: stay IDLE, both ready low.
REQ-019 EXEC: one ALU evaluation on latched operands; result and zero registered at end of cycle; EXEC -> RESP unconditionally.
REQ-020 RESP: respi_valid high only for owner; held with resp_result/resp_zero stable until respi_ready; then -> IDLE.
REQ-021 Latency: accept at edge N -> resp valid visible in cycle N+2; minimum 3 cycles per operation.
REQ-022 ALU arithmetic: WIDTH-bit wrap-around for ADD/SUB; shifts use b[4:0]; SLT signed, SLTU unsigned; undefined ctrl yields 0.
REQ-023 respi_ready asserted outside RESP or by non-owner SHALL be ignored.
REQ-024 reqi_valid changes during EXEC/RESP SHALL not affect latched operation.

Reset
REQ-025 reset SHALL force state IDLE, respi_valid 0, resp_result 0, resp_zero 0, busy 0, last_grant 1 (requester 0 wins first tie).
REQ-026 reset mid-operation SHALL abandon the in-flight operation with no response issued.

Configuration
REQ-027 With ALU_ARB_RR_EN defined: round-robin; on tie grant the requester not equal to last_grant; last_grant updates on each accept.
REQ-028 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins ties; last_grant unused.

Structure
REQ-029 Shared package alu_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and ALU control code constants.
REQ-030 SHALL instantiate the team's existing alu block as the single shared datapath sub-module; arbitration logic stays inline.

Verification
REQ-031 Req0 only: a=5, b=7, ctrl=000, resp0_ready=1 -> resp0_valid two cycles after accept, resp_result=12, resp_zero=0.
REQ-032 Req1 only: a=0x80000000, b=4, ctrl=110, funct7b5=1 -> resp_result=0xF8000000; funct7b5=0 -> 0x08000000.
REQ-033 Both valid continuously, ALU_ARB_RR_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0.
REQ-034 resp0_ready held low 5 cycles, a=b=9, ctrl=001 -> resp0_valid, resp_result=0, resp_zero=1 stable all 5 cycles; req1_ready low throughout.
REQ-035 reset asserted in EXEC -> next cycle IDLE, no respi_valid, resp_result=0; SLT a=0xFFFFFFFF, b=1, funct3=010 -> 1; funct3=011 -> 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - FSM state encoding (IDLE / EXEC / RESP)
//   - ALU control codes carried on reqi_ctrl
//   - funct3 value that turns the set-less-than operation into its unsigned form
//   - alu_op_t: the control fields latched with each accepted operation
// ---------------------------------------------------------------------------
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100; // signed/unsigned chosen by funct3
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SR  = 3'b110; // logical/arithmetic chosen by funct7b5
    localparam logic [2:0] ALU_XOR = 3'b111;

    // funct3 encodings for the compare operation
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    typedef struct packed {
        logic [2:0] ctrl;
        logic [2:0] funct3;
        logic       funct7b5;
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational ALU shared by both requesters of alu_arbiter.
// Ports:
//   a, b  (in,  WIDTH) operands
//   op    (in,  alu_op_t) control code, funct3, funct7b5
//   y     (out, WIDTH) result; codes outside the table give 0
// Notes: ADD/SUB wrap at WIDTH bits; shift amount is b[4:0]; the compare
// operation is unsigned when funct3 == F3_SLTU and signed otherwise.
// ---------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [4:0]       shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op.ctrl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: begin
                if (op.funct3 == F3_SLTU) begin
                    y = {{(WIDTH-1){1'b0}}, (a < b)};
                end else begin
                    y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                end
            end
            ALU_SLL: y = a << shamt;
            ALU_SR: begin
                if (op.funct7b5) begin
                    y = a_s >>> shamt;
                end else begin
                    y = a >> shamt;
                end
            end
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Two requesters share one ALU. In IDLE one valid requester is granted and
// its operation latched; EXEC evaluates it and registers result/zero; RESP
// holds the result for the owning requester until it is consumed.
// Arbitration: fixed priority (requester 0 wins) by default. Defining the
// macro ALU_ARB_RR_EN switches to round-robin on ties, using last_grant
// (reset to 1 so requester 0 wins the first tie).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake of requester N (0, 1)
//   reqN_a, reqN_b              operands (WIDTH)
//   reqN_ctrl, reqN_funct3,
//   reqN_funct7b5               ALU control fields
//   respN_valid / respN_ready   response handshake of requester N
//   resp_result, resp_zero      registered result and zero flag (shared)
//   busy                        high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic [2:0]       req0_funct3,
    input  logic             req0_funct7b5,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    input  logic [2:0]       req1_funct3,
    input  logic             req1_funct7b5,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,

    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_y;

    logic             any_valid;
    logic             grant;
    logic             accept;
    logic             owner_ready;

`ifdef ALU_ARB_RR_EN
    logic             last_grant_q, last_grant_d;
`endif

    assign any_valid   = req0_valid | req1_valid;
    assign accept      = (state_q == IDLE) && any_valid;
    // Only the owner's consume strobe matters; the other one is ignored.
    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    // Arbitration: a lone requester always wins; ties depend on the build.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            grant = ~last_grant_q;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = req1_valid;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        busy        = (state_q != IDLE);
        if (state_q == IDLE) begin
            req0_ready = req0_valid && (grant == 1'b0);
            req1_ready = req1_valid && (grant == 1'b1);
        end
        if (state_q == RESP) begin
            resp0_valid = (owner_q == 1'b0);
            resp1_valid = (owner_q == 1'b1);
        end
    end

    // Operation latch and result register next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        owner_d  = owner_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (accept) begin
            owner_d = grant;
            if (grant) begin
                a_d  = req1_a;
                b_d  = req1_b;
                op_d = '{ctrl: req1_ctrl, funct3: req1_funct3, funct7b5: req1_funct7b5};
            end else begin
                a_d  = req0_a;
                b_d  = req0_b;
                op_d = '{ctrl: req0_ctrl, funct3: req0_funct3, funct7b5: req0_funct7b5};
            end
        end
        if (state_q == EXEC) begin
            result_d = alu_y;
            zero_d   = (alu_y == '0);
        end
    end

`ifdef ALU_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant;
        end
    end
`endif

    // Control and visible result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            owner_q  <= owner_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Latched operands are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    alu_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    assign resp_result = result_q;
    assign resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_ctrl, req0_funct3, req1_ctrl, req1_funct3;
    logic         req0_funct7b5, req1_funct7b5;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [W-1:0] resp_result;
    logic         resp_zero, busy;

    int n_pass  = 0;
    int n_total = 0;
    logic ref_last;   // requester that won the most recent accept (1 after reset)

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .req0_funct3(req0_funct3), .req0_funct7b5(req0_funct7b5),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .req1_funct3(req1_funct3), .req1_funct7b5(req1_funct7b5),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference ALU straight from the operation table.
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] c, input logic [2:0] f3,
                                             input logic f7);
        int unsigned sh;
        longint signed sa;
        longint signed sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: begin
                if (f3 == 3'b011) return (a < b) ? 1 : 0;
                return (sa < sb) ? 1 : 0;
            end
            3'd5: return a << sh;
            3'd6: begin
                if (f7) return W'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
                return a >> sh;
            end
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic exp_grant(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            return ~ref_last;
`else
            return 1'b0;
`endif
        end
        return v1;
    endfunction

    // One complete transaction, entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input string nm, input logic v0, input logic v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] c0,
                          input logic [2:0] f30, input logic f70,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] c1,
                          input logic [2:0] f31, input logic f71, input int hold);
        logic g;
        logic [W-1:0] er;
        check_eq({nm, ".idle_busy"}, busy, 1'b0);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0; req0_funct3 = f30; req0_funct7b5 = f70;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1; req1_funct3 = f31; req1_funct7b5 = f71;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        g  = exp_grant(v0, v1);
        er = g ? ref_alu(a1, b1, c1, f31, f71) : ref_alu(a0, b0, c0, f30, f70);
        #1;
        check_eq({nm, ".ready0"}, req0_ready, v0 && !g);
        check_eq({nm, ".ready1"}, req1_ready, v1 && g);
        ref_last = g;
        @(negedge clk);
        // EXEC: disturb every request input and pulse both consume strobes
        check_eq({nm, ".exec_busy"}, busy, 1'b1);
        check_eq({nm, ".exec_rv"}, {resp1_valid, resp0_valid}, 2'b00);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_ctrl = 3'($urandom); req1_ctrl = 3'($urandom);
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        check_eq({nm, ".exec_rdy"}, {req1_ready, req0_ready}, 2'b00);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            check_eq({nm, ".resp_valid"}, {resp1_valid, resp0_valid}, g ? 2'b10 : 2'b01);
            check_eq({nm, ".result"}, resp_result, er);
            check_eq({nm, ".zero"}, resp_zero, er == '0);
            check_eq({nm, ".resp_rdy"}, {req1_ready, req0_ready}, 2'b00);
            if (g) begin resp0_ready = 1'b1; resp1_ready = (i == hold); end
            else   begin resp1_ready = 1'b1; resp0_ready = (i == hold); end
            @(negedge clk);
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        check_eq({nm, ".after_rv"}, {resp1_valid, resp0_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v0, v1, f70, f71;
        logic [2:0] c0, c1, f30, f31;
        logic [W-1:0] a0, b0, a1, b1;

        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_ctrl = 0; req1_ctrl = 0; req0_funct3 = 0; req1_funct3 = 0;
        req0_funct7b5 = 0; req1_funct7b5 = 0; resp0_ready = 0; resp1_ready = 0;
        ref_last = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst.busy", busy, 1'b0);
        check_eq("rst.rv", {resp1_valid, resp0_valid}, 2'b00);
        check_eq("rst.result", resp_result, '0);
        check_eq("rst.zero", resp_zero, 1'b0);
        check_eq("rst.ready", {req1_ready, req0_ready}, 2'b00);
        @(negedge clk);
        check_eq("idle.busy", busy, 1'b0);

        // Reset while in EXEC abandons the operation.
        req0_valid = 1; req0_a = 3; req0_b = 4; req0_ctrl = 3'b000;
        @(negedge clk);
        check_eq("mid.exec", busy, 1'b1);
        req0_valid = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid.busy", busy, 1'b0);
        check_eq("mid.rv", {resp1_valid, resp0_valid}, 2'b00);
        check_eq("mid.result", resp_result, '0);
        @(negedge clk);
        check_eq("mid.rv2", {resp1_valid, resp0_valid}, 2'b00);
        check_eq("mid.busy2", busy, 1'b0);
        ref_last = 1'b1;

        // Ties with both requesters valid throughout.
        for (int k = 0; k < 4; k++)
            run_op("tie", 1, 1, 32'd10, 32'd1, 3'b000, 3'b000, 1'b0,
                   32'd20, 32'd2, 3'b000, 3'b000, 1'b0, 0);

        run_op("add", 1, 0, 32'd5, 32'd7, 3'b000, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0);
        check_eq("add.12", resp_result, 32'd12);
        run_op("sra", 0, 1, 0, 0, 0, 0, 0, 32'h8000_0000, 32'd4, 3'b110, 3'b101, 1'b1, 0);
        check_eq("sra.val", resp_result, 32'hF800_0000);
        run_op("srl", 0, 1, 0, 0, 0, 0, 0, 32'h8000_0000, 32'd4, 3'b110, 3'b101, 1'b0, 0);
        check_eq("srl.val", resp_result, 32'h0800_0000);
        run_op("hold", 1, 0, 32'd9, 32'd9, 3'b001, 3'b000, 1'b0, 0, 0, 0, 0, 0, 5);
        check_eq("hold.zero", resp_zero, 1'b1);
        run_op("slt", 1, 0, 32'hFFFF_FFFF, 32'd1, 3'b100, 3'b010, 1'b0, 0, 0, 0, 0, 0, 0);
        check_eq("slt.val", resp_result, 32'd1);
        run_op("sltu", 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 3'b100, 3'b011, 1'b0, 0);
        check_eq("sltu.val", resp_result, 32'd0);

        for (int k = 0; k < 60; k++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            a0 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            b0 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            c0 = 3'($urandom); c1 = 3'($urandom);
            f30 = $urandom_range(0, 1) ? 3'b011 : 3'b010;
            f31 = 3'($urandom);
            f70 = 1'($urandom); f71 = 1'($urandom);
            run_op("rnd", v0, v1, a0, b0, c0, f30, f70, a1, b1, c1, f31, f71,
                   $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
